board_activity_leds: RTL
========================

# board_activity_leds

Board-level activity indicator for UART and other slow serial lines: it watches NCH raw pins and turns each transition into a visible LED pulse of fixed length followed by a forced off gap. Continuous traffic therefore shows as blinking rather than a faint glow. It sits in each board top-level, between the `soc_top` UART pins and the board LEDs, and replaces direct inversion of pin levels onto LEDs.

## Interface
- NCH, 4, number of monitored lines/LEDs (1..16)
- CLK_FREQ, 50_000_000, clk frequency in Hz
- ON_MS, 20, LED on time per activity event in ms (>=1)
- GAP_MS, 30, forced off time after each on pulse in ms (>=1)
- IDLE_LEVEL, 1'b1, idle level of monitored lines (UART idles high)
- LED_ACTIVE_LOW, 1'b0, 1 = LED lit when output is 0
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- sig_in  input  NCH  raw asynchronous lines (e.g. isp/user uart rx/tx)
- direct_mode  input  1  1 = LEDs follow synchronised line level (lit while line != IDLE_LEVEL)
- led  output  NCH  LED drive, polarity per LED_ACTIVE_LOW
- heartbeat  output  1  1 Hz liveness square wave (see Configuration)

## Operation
- ON_CYC = CLK_FREQ/1000*ON_MS, GAP_CYC = CLK_FREQ/1000*GAP_MS. Counter width = $clog2(max(ON_CYC,GAP_CYC)+1).
- Per channel: 2-flop synchroniser, then a previous-value register. Event = sync2 != prev, so both edges count.
- Per-channel FSM, states IDLE, ON, GAP:
  - IDLE: on event -> ON, counter = ON_CYC-1.
  - ON: counter decrements. An event sets pending and does not retrigger. At counter 0 -> GAP, counter = GAP_CYC-1.
  - GAP: counter decrements. An event sets pending. At counter 0: if pending (including an event in this same cycle) -> ON with counter reload and pending cleared, else -> IDLE.
- LED lit exactly in state ON.
- direct_mode=1: the FSM is held in IDLE with pending cleared, and led = lit while sync2 != IDLE_LEVEL. On the 1->0 transition the FSM starts in IDLE, and no event is generated by the mode switch itself.
- Channels are fully independent. Simultaneous events on all channels are all accepted.
- Reset values:
  - sync flops and prev = IDLE_LEVEL, so reset release creates no false event.
  - FSM = IDLE, counters 0, pending 0.
  - led = unlit (all 1 if LED_ACTIVE_LOW, else 0).
  - heartbeat = 0.
- Reset asserted mid-pulse clears everything immediately (asynchronous). LEDs go unlit without waiting for a clock.

## Timing
- An input change seen at rising edge k produces an event during cycle k+1 and state ON after edge k+2. led is registered, so it is lit after edge k+2.
- The on pulse lasts exactly ON_CYC cycles and the off gap exactly GAP_CYC cycles. Minimum period under continuous traffic is ON_CYC+GAP_CYC.
- direct_mode latency: led follows sig_in 2 edges after the change; led is registered from sync2 combined with the polarity.
- Input pulses shorter than one clk period may be missed. This is acceptable.

## Configuration
- `ACT_LED_HEARTBEAT_EN` defined: a counter toggles heartbeat every CLK_FREQ/2 cycles, giving a 1 Hz, 50 % duty wave. Reset value is 0 and the first toggle occurs after CLK_FREQ/2 cycles.
- Not defined: heartbeat is tied to constant 0 and no counter is synthesised. The port remains present so board tops do not change.

## Structure
- Package `act_led_pkg` holds:
  - typedef enum logic [1:0] act_state_t {ST_IDLE, ST_ON, ST_GAP}.
  - Function ms_to_cycles(freq, ms).
- Sub-module `act_led_channel` contains synchroniser, event detect, FSM, counter and pending for one line. The top instantiates NCH of them in a generate loop and adds the heartbeat logic.

## Test plan
Use CLK_FREQ=1000, ON_MS=5, GAP_MS=3, NCH=4, IDLE_LEVEL=1, LED_ACTIVE_LOW=0, i.e. ON_CYC=5 and GAP_CYC=3.
- Single falling edge on sig_in[0] at edge 10 -> led[0]=1 after edge 12 for exactly 5 cycles, then 0. Other LEDs stay 0.
- sig_in[1] toggling every cycle for 40 cycles -> led[1] shows repeating 5 on / 3 off. After the toggling stops, exactly one further pulse follows if an event was pending, then IDLE.
- Event arriving in the last GAP cycle -> next ON starts immediately with no IDLE cycle.
- Reset asserted 2 cycles into a pulse -> all led = 0 asynchronously. After release with sig_in idle, no pulse.
- direct_mode=1, sig_in[2] held 0 for 7 cycles -> led[2]=1 for 7 cycles, delayed 2 edges. Switching to 0 mid-level -> no spurious pulse.
- ACT_LED_HEARTBEAT_EN defined -> heartbeat toggles at cycles 500, 1000, 1500. Undefined -> heartbeat constant 0.

Source files
------------

// File: rtl/act_led_pkg.sv
// rtl/act_led_pkg.sv - shared types and helpers for the board activity LED block
package act_led_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ON,
        ST_GAP
    } act_state_t;

    function automatic int ms_to_cycles(input int freq, input int ms);
        return (freq / 1000) * ms;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/act_led_channel.sv
// rtl/act_led_channel.sv - one monitored line: synchroniser, edge detect, on/gap pulse FSM
module act_led_channel
    import act_led_pkg::*;
#(
    parameter int   ON_CYC         = 5,
    parameter int   GAP_CYC        = 3,
    parameter int   CW             = 3,
    parameter logic IDLE_LEVEL     = 1'b1,
    parameter logic LED_ACTIVE_LOW = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    input  logic direct_mode,
    output logic led
);

    localparam logic [CW-1:0] ON_LOAD  = CW'(ON_CYC - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYC - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          prev_q, prev_d;
    act_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          led_q, led_d;
    logic          evt;
    logic          lit;

    always_comb begin
        sync1_d = sig_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        evt     = (sync2_q != prev_q);
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;

        if (direct_mode) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            pend_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (evt) begin
                        state_d = ST_ON;
                        cnt_d   = ON_LOAD;
                    end
                end
                ST_ON: begin
                    // Events during the pulse are remembered, never retrigger it
                    pend_d = pend_q | evt;
                    if (cnt_q == '0) begin
                        state_d = ST_GAP;
                        cnt_d   = GAP_LOAD;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_q == '0) begin
                        if (pend_q || evt) begin
                            state_d = ST_ON;
                            cnt_d   = ON_LOAD;
                            pend_d  = 1'b0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d  = cnt_q - CW'(1);
                        pend_d = pend_q | evt;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                end
            endcase
        end

        lit   = direct_mode ? (sync2_q != IDLE_LEVEL) : (state_d == ST_ON);
        led_d = lit ^ LED_ACTIVE_LOW;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= IDLE_LEVEL;
            sync2_q <= IDLE_LEVEL;
            prev_q  <= IDLE_LEVEL;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            led_q   <= LED_ACTIVE_LOW;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            led_q   <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: rtl/board_activity_leds.sv
// rtl/board_activity_leds.sv - NCH activity LED channels plus optional 1 Hz heartbeat (ACT_LED_HEARTBEAT_EN)
module board_activity_leds
    import act_led_pkg::*;
#(
    parameter int   NCH            = 4,
    parameter int   CLK_FREQ       = 50_000_000,
    parameter int   ON_MS          = 20,
    parameter int   GAP_MS         = 30,
    parameter logic IDLE_LEVEL     = 1'b1,
    parameter logic LED_ACTIVE_LOW = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] sig_in,
    input  logic           direct_mode,
    output logic [NCH-1:0] led,
    output logic           heartbeat
);

    localparam int ON_CYC  = ms_to_cycles(CLK_FREQ, ON_MS);
    localparam int GAP_CYC = ms_to_cycles(CLK_FREQ, GAP_MS);
    localparam int CW      = $clog2(max_int(ON_CYC, GAP_CYC) + 1);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        act_led_channel #(
            .ON_CYC        (ON_CYC),
            .GAP_CYC       (GAP_CYC),
            .CW            (CW),
            .IDLE_LEVEL    (IDLE_LEVEL),
            .LED_ACTIVE_LOW(LED_ACTIVE_LOW)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .sig_in     (sig_in[i]),
            .direct_mode(direct_mode),
            .led        (led[i])
        );
    end

`ifdef ACT_LED_HEARTBEAT_EN
    localparam int HB_HALF = CLK_FREQ / 2;
    localparam int HW      = $clog2(HB_HALF + 1);

    logic [HW-1:0] hb_cnt_q, hb_cnt_d;
    logic          hb_q, hb_d;

    always_comb begin
        hb_cnt_d = hb_cnt_q + HW'(1);
        hb_d     = hb_q;
        if (hb_cnt_q == HW'(HB_HALF - 1)) begin
            hb_cnt_d = '0;
            hb_d     = ~hb_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hb_cnt_q <= '0;
            hb_q     <= 1'b0;
        end else begin
            hb_cnt_q <= hb_cnt_d;
            hb_q     <= hb_d;
        end
    end

    assign heartbeat = hb_q;
`else
    assign heartbeat = 1'b0;
`endif

endmodule
